// File: rtl/vga_hl_pkg.sv
// Shared definitions for the VGA field highlighter.
// Contents: field index constants, default selector base and colours,
// and a helper that decides whether a selector code belongs to a field.
package vga_hl_pkg;

  localparam int FLD_DIA   = 0;
  localparam int FLD_MES   = 1;
  localparam int FLD_ANO   = 2;
  localparam int FLD_HORA  = 3;
  localparam int FLD_MIN   = 4;
  localparam int FLD_SEG   = 5;
  localparam int FLD_HORAT = 6;
  localparam int FLD_MINT  = 7;
  localparam int FLD_SEGT  = 8;

  localparam int          NUM_FIELDS_DEF  = FLD_SEGT + 1;
  localparam int          BASE_SEL_DEF    = 2;
  localparam logic [11:0] HL_COLOR_DEF    = 12'hFFF;
  localparam logic [11:0] ALARM_COLOR_DEF = 12'hF00;

  // Each field owns two consecutive selector codes starting at
  // base + 2*field (one per digit).
  function automatic logic sel_in_field(input int sel, input int base, input int field);
    logic hit;
    hit = 1'b0;
    if (sel >= base) begin
      hit = (((sel - base) / 2) == field);
    end
    return hit;
  endfunction

endpackage

// File: rtl/vga_blink_timer.sv
// Frame-based blink timer for the field highlighter.
// Ports:
//   clk_i      pixel clock
//   rst_i      synchronous active-high reset
//   fb_i       frame-boundary strobe
//   restart_i  restart request (only honoured together with fb_i)
//   phase_o    blink phase that applies to the current pixel (1 = visible)
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic fb_i,
  input  logic restart_i,
  output logic phase_o
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (fb_i) begin
      // Restart has priority over a wrap landing on the same boundary.
      if (restart_i) begin
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // The frame-boundary pixel itself already uses the new phase.
  assign phase_o = phase_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/vga_field_highlighter.sv
// Pixel-stream post-processor: highlights the cursor field, blinks it while
// editing and flashes the display on alarm. All state changes at frame
// boundaries (falling edge of VS_IN). Colour and syncs are delayed 1 cycle.
// Ports:
//   CLK, RST                   pixel clock, synchronous active-high reset
//   COLOR_IN, SEL_IN           renderer pixel and its selector code
//   HS_IN, VS_IN               active-low syncs from the renderer
//   PTR_VALID, PTR_FIELD       cursor presence and selected field
//   EDIT, ALARMA               edit (blink) mode, alarm active
//   COLOR_OUT, HS, VS          processed pixel and delayed syncs
module vga_field_highlighter
  import vga_hl_pkg::*;
#(
  parameter int                 NUM_FIELDS   = NUM_FIELDS_DEF,
  parameter int                 SEL_W        = 5,
  parameter int                 FIELD_W      = 4,
  parameter int                 COLOR_W      = 12,
  parameter int                 BASE_SEL     = BASE_SEL_DEF,
  parameter int                 BLINK_FRAMES = 30,
  parameter logic [COLOR_W-1:0] HL_COLOR     = HL_COLOR_DEF,
  parameter logic [COLOR_W-1:0] ALARM_COLOR  = ALARM_COLOR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [COLOR_W-1:0] COLOR_IN,
  input  logic [SEL_W-1:0]   SEL_IN,
  input  logic               HS_IN,
  input  logic               VS_IN,
  input  logic               PTR_VALID,
  input  logic [FIELD_W-1:0] PTR_FIELD,
  input  logic               EDIT,
  input  logic               ALARMA,
  output logic [COLOR_W-1:0] COLOR_OUT,
  output logic               HS,
  output logic               VS
);

  logic               prev_vs_q;
  logic               act_valid_q, act_valid_d;
  logic [FIELD_W-1:0] act_field_q, act_field_d;
  logic               act_edit_q,  act_edit_d;
  logic               act_alarm_q, act_alarm_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               hs_q, vs_q;

  logic fb;
  logic smp_valid;
  logic restart;
  logic phase;
  logic sel_hit;

  always_comb begin
    fb        = ~VS_IN & prev_vs_q;
    // Out-of-range field indices are treated as "no cursor".
    smp_valid = PTR_VALID && (int'(PTR_FIELD) < NUM_FIELDS);
    restart   = fb && ((smp_valid != act_valid_q) ||
                       (PTR_FIELD != act_field_q) ||
                       (EDIT && !act_edit_q));

    act_valid_d = act_valid_q;
    act_field_d = act_field_q;
    act_edit_d  = act_edit_q;
    act_alarm_d = act_alarm_q;
    if (fb) begin
      act_valid_d = smp_valid;
      act_field_d = PTR_FIELD;
      act_edit_d  = EDIT;
      act_alarm_d = ALARMA;
    end
  end

  vga_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk_i    (CLK),
    .rst_i    (RST),
    .fb_i     (fb),
    .restart_i(restart),
    .phase_o  (phase)
  );

  // Pixel decision uses the _d values so the boundary pixel already sees
  // the newly sampled state.
  always_comb begin
    sel_hit = act_valid_d && sel_in_field(int'(SEL_IN), BASE_SEL, int'(act_field_d));
    if (COLOR_IN == '0) begin
      color_d = '0;
    end else if (sel_hit && (!act_edit_d || phase)) begin
      color_d = HL_COLOR;
    end else if (act_alarm_d && phase) begin
      color_d = ALARM_COLOR;
    end else begin
      color_d = COLOR_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_vs_q   <= 1'b1;
      act_valid_q <= 1'b0;
      act_field_q <= '0;
      act_edit_q  <= 1'b0;
      act_alarm_q <= 1'b0;
      color_q     <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
    end else begin
      prev_vs_q   <= VS_IN;
      act_valid_q <= act_valid_d;
      act_field_q <= act_field_d;
      act_edit_q  <= act_edit_d;
      act_alarm_q <= act_alarm_d;
      color_q     <= color_d;
      hs_q        <= HS_IN;
      vs_q        <= VS_IN;
    end
  end

  assign COLOR_OUT = color_q;
  assign HS        = hs_q;
  assign VS        = vs_q;

endmodule

// File: tb/tb_vga_field_highlighter.sv
module tb_vga_field_highlighter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] COLOR_IN = '0;
  logic [4:0]  SEL_IN = '0;
  logic        HS_IN = 1'b1;
  logic        VS_IN = 1'b1;
  logic        PTR_VALID = 1'b0;
  logic [3:0]  PTR_FIELD = '0;
  logic        EDIT = 1'b0;
  logic        ALARMA = 1'b0;

  logic [11:0] col0, col1;
  logic        hs0, vs0, hs1, vs1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  vga_field_highlighter #(.BLINK_FRAMES(2)) dut (
    .CLK(CLK), .RST(RST), .COLOR_IN(COLOR_IN), .SEL_IN(SEL_IN),
    .HS_IN(HS_IN), .VS_IN(VS_IN), .PTR_VALID(PTR_VALID), .PTR_FIELD(PTR_FIELD),
    .EDIT(EDIT), .ALARMA(ALARMA), .COLOR_OUT(col0), .HS(hs0), .VS(vs0)
  );

  vga_field_highlighter #(.BLINK_FRAMES(1)) dut1 (
    .CLK(CLK), .RST(RST), .COLOR_IN(COLOR_IN), .SEL_IN(SEL_IN),
    .HS_IN(HS_IN), .VS_IN(VS_IN), .PTR_VALID(PTR_VALID), .PTR_FIELD(PTR_FIELD),
    .EDIT(EDIT), .ALARMA(ALARMA), .COLOR_OUT(col1), .HS(hs1), .VS(vs1)
  );

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level behavioural model ----------------
  int          bf [2] = '{2, 1};
  logic        m_prev [2];
  logic        m_av [2];
  int          m_af [2];
  logic        m_ae [2];
  logic        m_aa [2];
  int          m_cnt [2];
  logic        m_ph [2];
  logic [11:0] exp_col [2];
  logic        exp_hs, exp_vs;
  logic        chk_en = 1'b0;

  always @(negedge CLK) begin
    logic [11:0] got;
    logic        valid_now, fb, restart, owns;
    if (chk_en) begin
      for (int b = 0; b < 2; b++) begin
        got = (b == 0) ? col0 : col1;
        check($sformatf("color_dut%0d", b), got, exp_col[b]);
      end
      check("hs_dut0", {11'b0, hs0}, {11'b0, exp_hs});
      check("vs_dut0", {11'b0, vs0}, {11'b0, exp_vs});
      check("hs_dut1", {11'b0, hs1}, {11'b0, exp_hs});
      check("vs_dut1", {11'b0, vs1}, {11'b0, exp_vs});
    end
    if (RST) begin
      for (int b = 0; b < 2; b++) begin
        m_prev[b] = 1'b1; m_av[b] = 1'b0; m_af[b] = 0; m_ae[b] = 1'b0;
        m_aa[b] = 1'b0; m_cnt[b] = 0; m_ph[b] = 1'b1; exp_col[b] = '0;
      end
      exp_hs = 1'b1;
      exp_vs = 1'b1;
      chk_en = 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        fb = !VS_IN && m_prev[b];
        if (fb) begin
          valid_now = PTR_VALID && (PTR_FIELD < 9);
          restart = (valid_now != m_av[b]) || (int'(PTR_FIELD) != m_af[b]) ||
                    (EDIT && !m_ae[b]);
          if (restart) begin
            m_cnt[b] = 0; m_ph[b] = 1'b1;
          end else if (m_cnt[b] + 1 == bf[b]) begin
            m_cnt[b] = 0; m_ph[b] = !m_ph[b];
          end else begin
            m_cnt[b] = m_cnt[b] + 1;
          end
          m_av[b] = valid_now; m_af[b] = int'(PTR_FIELD);
          m_ae[b] = EDIT; m_aa[b] = ALARMA;
        end
        m_prev[b] = VS_IN;
        owns = (SEL_IN >= 2) && ((int'(SEL_IN) - 2) / 2 == m_af[b]);
        if (COLOR_IN == 0)                              exp_col[b] = '0;
        else if (m_av[b] && owns && (!m_ae[b] || m_ph[b])) exp_col[b] = 12'hFFF;
        else if (m_aa[b] && m_ph[b])                    exp_col[b] = 12'hF00;
        else                                            exp_col[b] = COLOR_IN;
      end
      exp_hs = HS_IN;
      exp_vs = VS_IN;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pix(input logic [11:0] c, input logic [4:0] s);
    COLOR_IN = c;
    SEL_IN   = s;
    step();
  endtask

  task automatic vsync();
    COLOR_IN = '0;
    VS_IN = 1'b0;
    step();
    VS_IN = 1'b1;
    step();
  endtask

  task automatic rnd_cycle();
    COLOR_IN = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom);
    SEL_IN   = ($urandom_range(1) == 1) ? 5'($urandom_range(2, 21)) : 5'($urandom);
    HS_IN    = ($urandom_range(7) != 0);
    if ($urandom_range(15) == 0) begin
      PTR_VALID = ($urandom_range(3) != 0);
      PTR_FIELD = 4'($urandom_range(0, 10));
      EDIT      = 1'($urandom);
      ALARMA    = ($urandom_range(2) == 0);
    end
    step();
  endtask

  initial begin
    logic on;
    // reset
    RST = 1'b1;
    step(); step(); step();
    check("reset_color", col0, 12'h000);
    check("reset_hs", {11'b0, hs0}, 12'h001);
    check("reset_vs", {11'b0, vs0}, 12'h001);
    RST = 1'b0;
    step();

    // solid highlight of field 0
    PTR_VALID = 1'b1; PTR_FIELD = 4'd0; EDIT = 1'b0;
    vsync();
    pix(12'h0F0, 5'd2);  check("f0_sel2", col0, 12'hFFF);
    pix(12'h0F0, 5'd3);  check("f0_sel3", col0, 12'hFFF);
    pix(12'h0F0, 5'd4);  check("f0_sel4", col0, 12'h0F0);
    pix(12'h000, 5'd2);  check("f0_black", col0, 12'h000);

    // blinking field 8, two frames per half period
    PTR_FIELD = 4'd8; EDIT = 1'b1;
    for (int f = 0; f < 6; f++) begin
      on = (f < 2) || (f >= 4);
      vsync();
      pix(12'h0AB, 5'd18); check($sformatf("blink_f%0d_s18", f), col0, on ? 12'hFFF : 12'h0AB);
      pix(12'h0AB, 5'd19); check($sformatf("blink_f%0d_s19", f), col0, on ? 12'hFFF : 12'h0AB);
    end

    // mid-frame cursor move; restart beats a wrap at the same boundary
    PTR_FIELD = 4'd1;
    vsync();
    pix(12'h0AB, 5'd4); check("mv_a_s4", col0, 12'hFFF);
    vsync();
    pix(12'h0AB, 5'd4); check("mv_b_s4", col0, 12'hFFF);
    PTR_FIELD = 4'd2;
    pix(12'h0AB, 5'd4); check("mv_b_s4_after", col0, 12'hFFF);
    pix(12'h0AB, 5'd6); check("mv_b_s6_after", col0, 12'h0AB);
    vsync();
    pix(12'h0AB, 5'd6); check("mv_c_s6", col0, 12'hFFF);
    pix(12'h0AB, 5'd4); check("mv_c_s4", col0, 12'h0AB);

    // alarm flash on the single-frame blink instance
    PTR_VALID = 1'b0; EDIT = 1'b0; ALARMA = 1'b1;
    for (int f = 0; f < 3; f++) begin
      vsync();
      pix(12'h0AB, 5'd7); check($sformatf("alarm_f%0d", f), col1, (f % 2 == 0) ? 12'hF00 : 12'h0AB);
      pix(12'h000, 5'd7); check($sformatf("alarm_f%0d_black", f), col1, 12'h000);
    end

    // out-of-range field
    ALARMA = 1'b0; PTR_VALID = 1'b1; PTR_FIELD = 4'd9;
    vsync();
    pix(12'h0AB, 5'd20); check("fld9_s20", col0, 12'h0AB);
    pix(12'h0AB, 5'd2);  check("fld9_s2", col0, 12'h0AB);

    // reset mid-frame
    PTR_FIELD = 4'd0;
    vsync();
    pix(12'h0F0, 5'd2); check("pre_rst_hl", col0, 12'hFFF);
    RST = 1'b1; HS_IN = 1'b0; VS_IN = 1'b0;
    pix(12'h0F0, 5'd2);
    check("rst_mid_color", col0, 12'h000);
    check("rst_mid_hs", {11'b0, hs0}, 12'h001);
    check("rst_mid_vs", {11'b0, vs0}, 12'h001);
    RST = 1'b0; HS_IN = 1'b1; VS_IN = 1'b1;
    pix(12'h0F0, 5'd2); check("post_rst_nohl", col0, 12'h0F0);
    vsync();
    pix(12'h0F0, 5'd2); check("post_rst_fb_hl", col0, 12'hFFF);

    // sync delay
    HS_IN = 1'b0; pix(12'h000, 5'd0); check("hs_low", {11'b0, hs0}, 12'h000);
    HS_IN = 1'b1; pix(12'h000, 5'd0); check("hs_high", {11'b0, hs0}, 12'h001);
    VS_IN = 1'b0; pix(12'h000, 5'd0); check("vs_low", {11'b0, vs0}, 12'h000);
    VS_IN = 1'b1; pix(12'h000, 5'd0); check("vs_high", {11'b0, vs0}, 12'h001);

    // randomized frames, checked against the model every cycle
    for (int fr = 0; fr < 250; fr++) begin
      VS_IN = 1'b0;
      repeat ($urandom_range(1, 2)) rnd_cycle();
      VS_IN = 1'b1;
      repeat ($urandom_range(8, 24)) begin
        RST = ($urandom_range(60) == 0);
        rnd_cycle();
      end
      RST = 1'b0;
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
